mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 10, word-address width of the attached RAM.
REQ-002 Parameter: DATA_WIDTH, 32, RAM word width; only the value 32 is supported.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned.
REQ-013 rsp_valid  output  1  one-cycle completion pulse.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned or reserved-size request.
REQ-016 ram_addr  output  ADDR_WIDTH  word address, req_addr[ADDR_WIDTH+1:2].
REQ-017 ram_wen  output  1  RAM write enable.
REQ-018 ram_data  inout  32  shared RAM data bus.

Function
REQ-019 A request SHALL be accepted on a rising edge where req_valid && req_ready; addr, size, we, unsigned and wdata SHALL be latched at acceptance.
REQ-020 req_ready SHALL be 1 only in state IDLE.
REQ-021 FSM states SHALL be IDLE, LOAD, STORE, RMW_RD, RMW_WR and ERR.
REQ-022 From IDLE, an accepted request SHALL go to ERR if it is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or has size 11.
REQ-023 Otherwise, from IDLE, an accepted load SHALL go to LOAD, a word store to STORE, and a byte or half store to RMW_RD.
REQ-024 LOAD, STORE and ERR SHALL return to IDLE after one cycle; RMW_RD SHALL go to RMW_WR, and RMW_WR SHALL go to IDLE.
REQ-025 In LOAD and RMW_RD, ram_wen SHALL be 0, ram_data SHALL be undriven (Z), and the RAM word SHALL be captured at the cycle-ending edge.
REQ-026 In STORE and RMW_WR, ram_wen SHALL be 1 and ram_data SHALL be driven with the full word (STORE) or the merged word (RMW_WR).
REQ-027 ram_data SHALL be driven by the block only while ram_wen=1; there is no bus overlap.
REQ-028 Byte lanes SHALL be little-endian: the byte lane is addr[1:0] and the half lane is addr[1].
REQ-029 The RMW merge SHALL replace only the addressed lane(s) of the captured word.
REQ-030 The load result SHALL be the addressed lane, sign- or zero-extended to 32 bits per the latched unsigned flag; word loads SHALL pass through unchanged.
REQ-031 rsp_valid SHALL pulse for exactly one cycle on the edge leaving LOAD, STORE, RMW_WR or ERR, with rsp_rdata and rsp_err valid in the same cycle.
REQ-032 Latency from the accepting edge to rsp_valid SHALL be 1 cycle for LOAD, STORE and ERR, and 2 cycles for RMW.
REQ-033 A new request MAY be accepted in the rsp_valid cycle, giving back-to-back operation.
REQ-034 ERR SHALL perform no RAM access: ram_wen=0, rsp_err=1, rsp_rdata=0.
REQ-035 req_addr bits above ADDR_WIDTH+1 SHALL be ignored, so addresses alias (wrap-around).
REQ-036 In IDLE, ram_wen SHALL be 0 and ram_addr SHALL hold its last value.

Reset
REQ-037 While rst_n=0, asynchronously: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_wen=0, ram_addr=0, ram_data=Z.
REQ-038 Reset during RMW_RD or RMW_WR SHALL abort the operation with no RAM write and no response.
REQ-039 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-040 Package mem_pkg SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W) and the state enum.
REQ-041 Lane merge and load extraction/extension SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-042 Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> ram_wen=1 for exactly one cycle; load rsp 1 cycle after accept, rdata=0xDEADBEEF, err=0.
REQ-043 Byte store 0xA5 to 0x11 over word 0xDEADBEEF -> RMW_RD then RMW_WR, RAM word=0xDEADA5EF; rsp 2 cycles after accept.
REQ-044 Signed byte load 0x11 -> rdata=0xFFFFFFA5; unsigned -> 0x000000A5; signed half load 0x12 -> 0xFFFFDEAD.
REQ-045 Word load 0x13 -> rsp_err=1, rdata=0, ram_wen never 1; req_size=11 -> same error response.
REQ-046 Assert rst_n=0 during RMW_WR -> ram_wen falls immediately, RAM word unchanged, no rsp_valid; req_ready=1 in the first cycle after release.
REQ-047 Back-to-back load, store, load with req_valid held high -> each accepted in the prior rsp_valid cycle; ram_data never driven while ram_wen=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states
// and the request legality rule.
package mem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_ERR
    } state_t;

    // A request is illegal when its size is reserved or its address is not
    // naturally aligned for that size.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] byte_off);
        req_is_bad = (size == SIZE_RSV)
                  || ((size == SIZE_H) && byte_off[0])
                  || ((size == SIZE_W) && (byte_off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: merges store data into a captured RAM word
// and extracts/extends load data from the RAM bus. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic        is_unsigned,
    input  logic [31:0] base_word,
    input  logic [31:0] store_data,
    input  logic [31:0] rd_word,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    // Byte to 32 bits, sign- or zero-extended.
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
        logic signed [7:0]  b_s;
        logic signed [31:0] wide;
        b_s  = b;
        wide = b_s;
        ext_byte = uns ? {24'h000000, b} : wide;
    endfunction

    // Half-word to 32 bits, sign- or zero-extended.
    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
        logic signed [15:0] h_s;
        logic signed [31:0] wide;
        h_s  = h;
        wide = h_s;
        ext_half = uns ? {16'h0000, h} : wide;
    endfunction

    // Replace only the addressed lane(s) of the captured word.
    always_comb begin
        merged_word = base_word;
        case (size)
            SIZE_B:  merged_word[{byte_off, 3'b000} +: 8]    = store_data[7:0];
            SIZE_H:  merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
            SIZE_W:  merged_word = store_data;
            default: merged_word = base_word;
        endcase
    end

    // Pick the addressed lane off the bus and extend it; words pass through.
    always_comb begin
        load_data = rd_word;
        case (size)
            SIZE_B:  load_data = ext_byte(rd_word[{byte_off, 3'b000} +: 8], is_unsigned);
            SIZE_H:  load_data = ext_half(rd_word[{byte_off[1], 4'b0000} +: 16], is_unsigned);
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit in front of a single-port word RAM with a shared
// tri-state data bus. Sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wen,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_t                state_q, state_d;
    logic [1:0]            size_p0;
    logic [1:0]            off_p0;
    logic                  uns_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic [DATA_WIDTH-1:0] word_p1;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  accept;
    logic                  req_bad;
    logic                  unused_addr_hi;

    // Upper address bits are dropped, so addresses alias across the RAM.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_bad   = req_is_bad(req_size, req_addr[1:0]);

    // State register; reset aborts any RMW in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and RAM write-side controls.
    always_comb begin
        state_d = state_q;
        ram_wen = 1'b0;
        wr_word = merged_word;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = ST_ERR;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_size == SIZE_W) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_STORE: begin
                ram_wen = 1'b1;
                wr_word = wdata_p0;
                state_d = ST_IDLE;
            end
            ST_RMW_RD: begin
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                ram_wen = 1'b1;
                wr_word = merged_word;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The bus is only ever driven while writing.
    assign ram_data = ram_wen ? wr_word : {DATA_WIDTH{1'bz}};

    // Request attributes and RAM address captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            size_p0  <= SIZE_B;
            off_p0   <= 2'b00;
            uns_p0   <= 1'b0;
        end else if (accept) begin
            ram_addr <= req_addr[ADDR_WIDTH+1:2];
            size_p0  <= req_size;
            off_p0   <= req_addr[1:0];
            uns_p0   <= req_unsigned;
        end
    end

    // Store data at acceptance; RAM word at the end of the RMW read cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_p0 <= req_wdata;
        end
        if (state_q == ST_RMW_RD) begin
            word_p1 <= ram_data;
        end
    end

    mem_lane_align u_align (
        .size        (size_p0),
        .byte_off    (off_p0),
        .is_unsigned (uns_p0),
        .base_word   (word_p1),
        .store_data  (wdata_p0),
        .rd_word     (ram_data),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // Completion pulse on the edge leaving a terminal state; load data is
    // sampled off the bus at that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state_q == ST_LOAD) || (state_q == ST_STORE)
                      || (state_q == ST_RMW_WR) || (state_q == ST_ERR);
            rsp_err   <= (state_q == ST_ERR);
            rsp_rdata <= (state_q == ST_LOAD) ? load_data : '0;
        end
    end

endmodule
